// File: rtl/uart_tx_serializer_pkg.sv
// rtl/uart_tx_serializer_pkg.sv - shared UART encodings: FSM states, parity types, line levels
// Optional feature macro UART_TX_STOP2_EN uses the STOP_2 state.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP_2 = 3'd5
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - parallel request / serial line bundle for the UART TX framer
// UART_TX_STOP2_EN adds the STOP2 request field.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
`ifdef UART_TX_STOP2_EN
  logic                  STOP2;
`endif
  logic                  TX_OUT;
  logic                  busy;

  // master = system-side TX controller, slave = serializer
  modport master (
    output P_DATA,
    output data_valid,
    output PAR_EN,
    output PAR_TYP,
`ifdef UART_TX_STOP2_EN
    output STOP2,
`endif
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  data_valid,
    input  PAR_EN,
    input  PAR_TYP,
`ifdef UART_TX_STOP2_EN
    input  STOP2,
`endif
    output TX_OUT,
    output busy
  );

endinterface

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational UART parity bit, shared by the TX and RX paths
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  PAR_TYP,
  output logic                  par_bit
);

  assign par_bit = (PAR_TYP == PAR_ODD) ? ~^data : ^data;

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX framer: start, LSB-first data, optional parity, stop
// UART_TX_STOP2_EN adds a per-frame second stop bit selected by STOP2.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_serializer_if.slave tx_if
);

  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic                  tx_q, tx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit;
  logic                  load;
  logic                  busy;
  logic                  accept;
`ifdef UART_TX_STOP2_EN
  logic                  stop2_q;
`endif

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_q),
    .PAR_TYP (par_typ_q),
    .par_bit (par_bit)
  );

  // The stop cycle accepts a new request so frames can run back to back.
  always_comb begin
    busy = (state_q == START) || (state_q == DATA) || (state_q == PARITY);
`ifdef UART_TX_STOP2_EN
    if (state_q == STOP && stop2_q) begin
      busy = 1'b1;
    end
`endif
  end

  assign accept  = tx_if.data_valid && !busy;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= IDLE_LVL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
    end
  end

  // tx_d is the line level for the state being entered, so TX_OUT tracks state_q.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = IDLE_LVL;
        if (accept) begin
          state_d = START;
          tx_d    = START_LVL;
          load    = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = data_q[0];
      end
      DATA: begin
        if (cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit;
          end else begin
            state_d = STOP;
            tx_d    = STOP_LVL;
          end
        end else begin
          cnt_d = cnt_nxt;
          tx_d  = data_q[cnt_nxt];
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_LVL;
      end
      STOP: begin
`ifdef UART_TX_STOP2_EN
        if (stop2_q) begin
          state_d = STOP_2;
          tx_d    = STOP_LVL;
        end else
`endif
        if (accept) begin
          state_d = START;
          tx_d    = START_LVL;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = IDLE_LVL;
        end
      end
`ifdef UART_TX_STOP2_EN
      STOP_2: begin
        if (accept) begin
          state_d = START;
          tx_d    = START_LVL;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
          tx_d    = IDLE_LVL;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= 1'b0;
`endif
    end else if (load) begin
      data_q    <= tx_if.P_DATA;
      par_en_q  <= tx_if.PAR_EN;
      par_typ_q <= tx_if.PAR_TYP;
`ifdef UART_TX_STOP2_EN
      stop2_q   <= tx_if.STOP2;
`endif
    end
  end

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.busy   = busy;

endmodule
